// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states,
// and helpers that decode access size and legality.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, DONE, ERR} lsu_state_t;

  // Access size in bytes; 0 marks an encoding with no defined width.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) return (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
    return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
           (funct3 == LBU) || (funct3 == LHU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte mask and shifted store data for a two-word
// window, plus extraction and sign/zero extension of load data.
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_buf0,
  input  logic [31:0] i_buf1,
  output logic [7:0]  o_mask,
  output logic [63:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [2:0]  w_n;
  logic [7:0]  w_bytes;
  logic [31:0] w_keep;
  logic [31:0] w_sh;

  always_comb begin
    w_n = size_of(i_funct3);
    case (w_n)
      3'd1:    begin w_bytes = 8'b0000_0001; w_keep = 32'h0000_00FF; end
      3'd2:    begin w_bytes = 8'b0000_0011; w_keep = 32'h0000_FFFF; end
      3'd4:    begin w_bytes = 8'b0000_1111; w_keep = 32'hFFFF_FFFF; end
      default: begin w_bytes = '0;           w_keep = '0;            end
    endcase
    o_mask  = w_bytes << i_off;
    o_wdata = {32'b0, i_wdata & w_keep} << {i_off, 3'b000};
    w_sh    = 32'({i_buf1, i_buf0} >> {i_off, 3'b000});
    // funct3[2] distinguishes the unsigned loads (LBU/LHU)
    case (w_n)
      3'd1:    o_rdata = i_funct3[2] ? {24'b0, w_sh[7:0]}  : {{24{w_sh[7]}},  w_sh[7:0]};
      3'd2:    o_rdata = i_funct3[2] ? {16'b0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
      default: o_rdata = w_sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-addressed, byte-enabled data RAM.
// Splits word-crossing accesses into two RAM cycles and returns one response.
module load_store_unit import lsu_pkg::*; #(
  parameter int unsigned MEM_WORD_SIZE = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [3:0]  byte_enable,
  output logic [31:0] addr,
  output logic [31:0] w_data,
  input  logic [31:0] r_data
);

  lsu_state_t  r_state;
  logic        r_we, r_split;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_wdata, r_buf0, r_buf1;
  logic        r_req_ready, r_resp_valid, r_resp_err, r_mem_read, r_mem_write;
  logic [31:0] r_resp_rdata, r_ram_addr, r_w_data;
  logic [3:0]  r_byte_enable;

  logic        w_idle, w_split, w_oor, w_bad;
  logic [2:0]  w_f3;
  logic [1:0]  w_off;
  logic [31:0] w_wd, w_ld0, w_ld1, w_ldata;
  logic [7:0]  w_mask;
  logic [63:0] w_sdata;
  logic [29:0] w_w0, w_w1, w_rw1;

  // The aligner sees the live request in IDLE and the latched one afterwards;
  // the word being read this cycle bypasses its buffer so the response can
  // be registered on the same edge that captures it.
  assign w_idle = (r_state == IDLE);
  assign w_f3   = w_idle ? req_funct3     : r_funct3;
  assign w_off  = w_idle ? req_addr[1:0]  : r_addr[1:0];
  assign w_wd   = w_idle ? req_wdata      : r_wdata;
  assign w_ld0  = (r_state == ACC0) ? r_data : r_buf0;
  assign w_ld1  = (r_state == ACC1) ? r_data : r_buf1;

  lsu_align u_align (
    .i_funct3 (w_f3),
    .i_off    (w_off),
    .i_wdata  (w_wd),
    .i_buf0   (w_ld0),
    .i_buf1   (w_ld1),
    .o_mask   (w_mask),
    .o_wdata  (w_sdata),
    .o_rdata  (w_ldata)
  );

  assign w_w0    = req_addr[31:2];
  assign w_w1    = w_w0 + 30'd1;
  assign w_rw1   = r_addr[31:2] + 30'd1;
  assign w_split = |w_mask[7:4];
  assign w_oor   = ({2'b0, w_w0} >= MEM_WORD_SIZE) ||
                   (w_split && ({2'b0, w_w1} >= MEM_WORD_SIZE));
  assign w_bad   = !is_legal(req_we, req_funct3) || w_oor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_we          <= 1'b0;
      r_split       <= 1'b0;
      r_funct3      <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_buf0        <= '0;
      r_buf1        <= '0;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= '0;
      r_resp_err    <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_byte_enable <= '0;
      r_ram_addr    <= '0;
      r_w_data      <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_we        <= req_we;
          r_funct3    <= req_funct3;
          r_addr      <= req_addr;
          r_wdata     <= req_wdata;
          r_split     <= w_split;
          r_req_ready <= 1'b0;
          if (w_bad) begin
            r_state      <= ERR;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end else begin
            r_state       <= ACC0;
            r_mem_read    <= !req_we;
            r_mem_write   <= req_we;
            r_byte_enable <= w_mask[3:0];
            r_ram_addr    <= {2'b0, w_w0};
            r_w_data      <= req_we ? w_sdata[31:0] : '0;
          end
        end
        ACC0, ACC1: begin
          if (r_state == ACC0) r_buf0 <= r_data;
          else                 r_buf1 <= r_data;
          if (r_state == ACC0 && r_split) begin
            r_state       <= ACC1;
            r_byte_enable <= w_mask[7:4];
            r_ram_addr    <= {2'b0, w_rw1};
            r_w_data      <= r_we ? w_sdata[63:32] : '0;
          end else begin
            r_state       <= DONE;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_byte_enable <= '0;
            r_ram_addr    <= '0;
            r_w_data      <= '0;
            r_resp_valid  <= 1'b1;
            r_resp_err    <= 1'b0;
            r_resp_rdata  <= r_we ? '0 : w_ldata;
          end
        end
        DONE, ERR: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_resp_err;
  assign MemRead     = r_mem_read;
  assign MemWrite    = r_mem_write;
  assign byte_enable = r_byte_enable;
  assign addr        = r_ram_addr;
  assign w_data      = r_w_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural byte-enabled RAM.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, MemRead, MemWrite;
  logic [31:0] resp_rdata, addr, w_data, r_data;
  logic [3:0]  byte_enable;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORD_SIZE(256)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .MemRead(MemRead), .MemWrite(MemWrite),
    .byte_enable(byte_enable), .addr(addr), .w_data(w_data), .r_data(r_data)
  );

  // RAM model: combinational read, byte-lane write on the rising edge.
  logic [31:0] mem [256];
  logic        init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]   <= 32'h4433_2211;
      mem[5]   <= 32'h8877_6655;
      mem[6]   <= 32'h1122_3344;
      mem[255] <= 32'hCAFE_F00D;
    end else if (MemWrite && addr < 32'd256) begin
      for (int b = 0; b < 4; b++)
        if (byte_enable[b]) mem[addr[7:0]][8*b +: 8] <= w_data[8*b +: 8];
    end
  end
  always_comb r_data = (addr < 32'd256) ? mem[addr[7:0]] : 32'h0;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Scoreboard: {err, rdata} pushed on issue, popped when resp_valid shows.
  logic [32:0] exp_q [$];
  logic [32:0] exp_e;
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
      end else begin
        exp_e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, exp_e[31:0]);
        check("resp_err", 32'(resp_err), 32'(exp_e[32]));
      end
    end
  end

  // Per-cycle samples of the RAM port after acceptance (index = cycle number).
  logic        s_mr [1:5], s_mw [1:5], s_rdy [1:5];
  logic [3:0]  s_be [1:5];
  logic [31:0] s_addr [1:5], s_wd [1:5];
  int          lat;

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    wait_ready();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    exp_q.push_back({exp_err, exp_rd});
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    lat = 0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (c <= 5) begin
        s_mr[c] = MemRead; s_mw[c] = MemWrite; s_rdy[c] = req_ready;
        s_be[c] = byte_enable; s_addr[c] = addr; s_wd[c] = w_data;
      end
      if (resp_valid === 1'b1) lat = c;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected $finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; init_mem = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_ram_strobes", {30'b0, MemRead, MemWrite}, 32'd0);
    check("rst_byte_enable", 32'(byte_enable), 32'd0);
    check("rst_addr", addr, 32'h0);
    check("rst_w_data", w_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 init_mem = 1'b0; reset = 1'b0;

    // Split LW across words 4/5
    do_req(1'b0, 3'b010, 32'h12, 32'h0, 32'h6655_4433, 1'b0);
    check("lw_split_lat", lat, 3);
    check("lw_split_c1", {s_mr[1], s_mw[1], s_rdy[1], 1'b0, s_be[1]}, 32'h8C);
    check("lw_split_c1_addr", s_addr[1], 32'd4);
    check("lw_split_c2", {s_mr[2], s_mw[2], s_rdy[2], 1'b0, s_be[2]}, 32'h83);
    check("lw_split_c2_addr", s_addr[2], 32'd5);
    check("lw_split_c3", {s_mr[3], s_mw[3], s_rdy[3], 1'b0, s_be[3]}, 32'h00);

    // Aligned SW
    do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    check("sw_lat", lat, 2);
    check("sw_c1", {s_mr[1], s_mw[1], s_rdy[1], 1'b0, s_be[1]}, 32'h4F);
    check("sw_c1_addr", s_addr[1], 32'd4);
    check("sw_c1_wdata", s_wd[1], 32'hDEAD_BEEF);
    check("sw_c2_idle_port", {s_mw[2], s_addr[2][30:0]}, 32'h0);
    check("sw_mem4", mem[4], 32'hDEAD_BEEF);

    // SB lane 3, upper data bits must be masked off
    do_req(1'b1, 3'b000, 32'h13, 32'h1234_56A5, 32'h0, 1'b0);
    check("sb_be", 32'(s_be[1]), 32'h8);
    check("sb_wdata", s_wd[1], 32'hA500_0000);
    check("sb_mem4", mem[4], 32'hA5AD_BEEF);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFA5, 1'b0);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00A5, 1'b0);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_A5AD, 1'b0);
    do_req(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0);
    check("lhu_lat", lat, 2);

    // Split SH across words 5/6
    do_req(1'b1, 3'b001, 32'h17, 32'hFFFF_BEEF, 32'h0, 1'b0);
    check("sh_split_lat", lat, 3);
    check("sh_c1", {s_addr[1][7:0], s_wd[1][31:24], 4'b0, s_be[1]}, 32'h05_EF_08);
    check("sh_c2", {s_addr[2][7:0], s_wd[2][7:0], 4'b0, s_be[2]}, 32'h06_BE_01);
    check("sh_mem5", mem[5], 32'hEF77_6655);
    check("sh_mem6", mem[6], 32'h1122_33BE);
    do_req(1'b0, 3'b010, 32'h17, 32'h0, 32'h2233_BEEF, 1'b0);

    // Last word in range
    do_req(1'b0, 3'b010, 32'h3FC, 32'h0, 32'hCAFE_F00D, 1'b0);
    check("lw_last_lat", lat, 2);
    do_req(1'b0, 3'b000, 32'h3FF, 32'h0, 32'hFFFF_FFCA, 1'b0);

    // Errors: no RAM activity, response one cycle after acceptance
    do_req(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
    check("err_f3_lat", lat, 1);
    check("err_f3_port", {s_mr[1], s_mw[1], s_rdy[1]}, 32'h0);
    do_req(1'b1, 3'b010, 32'h3FE, 32'h5555_5555, 32'h0, 1'b1);
    check("err_sw_split_lat", lat, 1);
    check("err_sw_split_nowrite", {s_mw[1], s_mw[2]}, 32'h0);
    check("err_sw_mem255", mem[255], 32'hCAFE_F00D);
    do_req(1'b1, 3'b100, 32'h0, 32'h1, 32'h0, 1'b1);
    do_req(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
    do_req(1'b0, 3'b101, 32'h3FF, 32'h0, 32'h0, 1'b1);
    do_req(1'b0, 3'b001, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b1);

    // Reset during ACC1 of a split store: word 8 committed, word 9 untouched
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h22; req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_acc0", {MemWrite, 3'b0, byte_enable, addr[7:0]}, 32'h8C_08);
    check("rst_mid_acc0_wdata", w_data, 32'h5678_0000);
    @(negedge clk);
    check("rst_mid_acc1", {MemWrite, 3'b0, byte_enable, addr[7:0]}, 32'h83_09);
    reset = 1'b1;
    #1;
    check("rst_mid_memwrite", 32'(MemWrite), 32'd0);
    check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_mid_mem8", mem[8], 32'h5678_0000);
    check("rst_mid_mem9", mem[9], 32'h0);
    repeat (4) @(negedge clk);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h5678_0000, 1'b0);
    do_req(1'b0, 3'b010, 32'h24, 32'h0, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
